// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator stage of a DSP48A1-style slice: X/Z operand select, add/subtract
// with carry-in, P accumulator register. Optional sticky overflow flag under OVF_DETECT_EN.
module dsp_post_adder_acc #(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYOUTREG = 1'b1,
    parameter bit OPMODEREG   = 1'b1,
    parameter bit CREG        = 1'b1,
    parameter bit CARRYINREG  = 1'b1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [35:0] m_i,
    input  logic [47:0] c_i,
    input  logic [47:0] dab_i,
    input  logic [47:0] pcin_i,
    input  logic [7:0]  opmode_i,
    input  logic        carryin_i,
    input  logic        cep_i,
    input  logic        cec_i,
    input  logic        ceopmode_i,
    input  logic        cecarryin_i,
    input  logic        cecarryout_i,
    output logic [47:0] p_o,
    output logic [47:0] pcout_o,
    output logic        carryout_o
`ifdef OVF_DETECT_EN
    ,
    output logic        ovf_o
`endif
);

    logic [7:0]  opmode_q;
    logic [47:0] c_q;
    logic        cyi_q;
    logic [47:0] p_q;
    logic        carryout_q;

    logic [7:0]  opmode_eff;
    logic [47:0] c_eff;
    logic        cin_eff;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] x_cin;
    logic [48:0] result;
    logic        sub;

    // Bits [6:4] of OPMODE have no function in this stage.
    logic unused_opmode;
    assign unused_opmode = ^{opmode_i[6:4], opmode_q[6:4]};

    assign opmode_eff = OPMODEREG  ? opmode_q : opmode_i;
    assign c_eff      = CREG       ? c_q      : c_i;
    assign cin_eff    = CARRYINREG ? cyi_q    : carryin_i;
    assign sub        = opmode_eff[7];

    always_comb begin
        x_mux = '0;
        case (opmode_eff[1:0])
            2'b00:   x_mux = '0;
            2'b01:   x_mux = {12'b0, m_i};
            2'b10:   x_mux = p_q;
            default: x_mux = dab_i;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (opmode_eff[3:2])
            2'b00:   z_mux = '0;
            2'b01:   z_mux = pcin_i;
            2'b10:   z_mux = p_q;
            default: z_mux = c_eff;
        endcase
    end

    // Carry-in joins X before the add/subtract so subtract yields Z - (X + CIN).
    always_comb begin
        x_cin  = {1'b0, x_mux} + {48'b0, cin_eff};
        result = sub ? ({1'b0, z_mux} - x_cin) : ({1'b0, z_mux} + x_cin);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            opmode_q   <= '0;
            c_q        <= '0;
            cyi_q      <= 1'b0;
            p_q        <= '0;
            carryout_q <= 1'b0;
        end else begin
            if (ceopmode_i)   opmode_q   <= opmode_i;
            if (cec_i)        c_q        <= c_i;
            if (cecarryin_i)  cyi_q      <= carryin_i;
            if (cep_i)        p_q        <= result[47:0];
            if (cecarryout_i) carryout_q <= result[48];
        end
    end

    assign p_o        = PREG ? p_q : result[47:0];
    assign pcout_o    = p_o;
    assign carryout_o = CARRYOUTREG ? carryout_q : result[48];

`ifdef OVF_DETECT_EN
    logic ovf_q;
    logic ovf_now;

    // Signed overflow: effective operand signs agree but the result sign differs.
    assign ovf_now = (z_mux[47] == (x_mux[47] ^ sub)) && (result[47] != z_mux[47]);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (cep_i && ovf_now) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule
